pc_sequencer: RTL and testbench

Program-counter sequencer directly upstream of the instruction fetch stage. Each cycle it produces the 72-bit word address that instruction fetch reads; consecutive instructions are one address apart. It handles stall, taken-branch redirect, call/return through a small return-address stack (RAS), and halt/resume. It owns the only PC register in the front end.

---
 rtl/pc_pkg.sv | 14 +
 rtl/ras_stack.sv | 62 ++++++
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the front-end program-counter sequencer.
// Holds the FSM state encoding and the default address geometry.
package pc_pkg;

    localparam int unsigned ADDR_W = 72;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } pc_state_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count and registered
// overflow/underflow pulses.
module ras_stack #(
    parameter int unsigned ADDR_W    = 72,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic [PTR_W-1:0]  w_top_idx;

    // r_ptr is the next free slot; when full it also points at the oldest entry.
    assign w_top_idx   = r_ptr - PTR_W'(1);
    assign o_top       = r_mem[w_top_idx];
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(RAS_DEPTH));
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= i_push && o_full;
            r_underflow <= i_pop && !i_push && o_empty;
            if (i_push) begin
                r_mem[r_ptr] <= i_push_data;
                r_ptr        <= r_ptr + PTR_W'(1);
                if (!o_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (i_pop && !o_empty) begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Front-end program counter: BOOT/RUN/HALT FSM, next-address selection and
// the PC register feeding instruction fetch.
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = pc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(pc_pkg::RESET_PC),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              call_valid,
    input  logic              ret_valid,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] address,
    output logic              fetch_valid,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic [1:0]        state
);

    import pc_pkg::*;

    pc_state_e         r_state;
    pc_state_e         w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              r_fetch_valid;
    logic              w_next_fetch_valid;
    logic              r_boot_armed;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_unused_full;

    assign w_addr_inc  = r_addr + ADDR_W'(1);
    assign address     = r_addr;
    assign fetch_valid = r_fetch_valid;
    assign state       = r_state;

    always_comb begin
        w_next_state       = r_state;
        w_next_addr        = r_addr;
        w_next_fetch_valid = 1'b0;
        w_push             = 1'b0;
        w_pop              = 1'b0;
        unique case (r_state)
            // Release is asynchronous to clk, so BOOT holds for the first full
            // cycle after the first edge and exits on the second.
            StBoot: begin
                if (r_boot_armed) begin
                    w_next_state       = StRun;
                    w_next_fetch_valid = 1'b1;
                end
            end
            StRun: begin
                if (halt) begin
                    w_next_state = StHalt;
                end else if (redirect_valid) begin
                    w_next_addr        = redirect_target;
                    w_next_fetch_valid = 1'b1;
                    w_push             = call_valid;
                end else if (ret_valid) begin
                    w_pop              = 1'b1;
                    w_next_addr        = w_ras_empty ? w_addr_inc : w_ras_top;
                    w_next_fetch_valid = 1'b1;
                end else if (!stall) begin
                    w_next_addr        = w_addr_inc;
                    w_next_fetch_valid = 1'b1;
                end
            end
            StHalt: begin
                if (resume && !halt) begin
                    w_next_state       = StRun;
                    w_next_fetch_valid = 1'b1;
                end
            end
            default: w_next_state = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StBoot;
            r_addr        <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_boot_armed  <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_addr        <= w_next_addr;
            r_fetch_valid <= w_next_fetch_valid;
            r_boot_armed  <= 1'b1;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_addr_inc),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_unused_full),
        .o_overflow  (ras_overflow),
        .o_underflow (ras_underflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset sequence,
// then random stimulus against a queue-based reference model.
module tb_pc_sequencer;

    localparam int AW = 72;
    localparam logic [AW-1:0] ONES = {AW{1'b1}};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic          call_valid = 1'b0;
    logic          ret_valid = 1'b0;
    logic          halt = 1'b0;
    logic          resume = 1'b0;
    logic [AW-1:0] address;
    logic          fetch_valid;
    logic          ras_overflow;
    logic          ras_underflow;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W    (AW),
        .RESET_PC  ({AW{1'b0}}),
        .RAS_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call_valid      (call_valid),
        .ret_valid       (ret_valid),
        .halt            (halt),
        .resume          (resume),
        .address         (address),
        .fetch_valid     (fetch_valid),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow),
        .state           (state)
    );

    typedef struct {
        logic          st, rv;
        logic [AW-1:0] tg;
        logic          cv, rt, hl, rs;
        logic [AW-1:0] e_addr;
        logic          e_fv;
        logic [1:0]    e_st;
        logic          e_ovf, e_unf;
    } vec_t;

    function automatic logic [AW-1:0] A(input longint unsigned x);
        return AW'(x);
    endfunction

    function automatic vec_t mk(input int st, input int rv, input logic [AW-1:0] tg,
                                input int cv, input int rt, input int hl, input int rs,
                                input logic [AW-1:0] ea, input int ef, input int es,
                                input int eo, input int eu);
        vec_t v;
        v.st = st[0]; v.rv = rv[0]; v.tg = tg; v.cv = cv[0];
        v.rt = rt[0]; v.hl = hl[0]; v.rs = rs[0];
        v.e_addr = ea; v.e_fv = ef[0]; v.e_st = es[1:0];
        v.e_ovf = eo[0]; v.e_unf = eu[0];
        return v;
    endfunction

    task automatic drive(input logic st, input logic rv, input logic [AW-1:0] tg,
                         input logic cv, input logic rt, input logic hl, input logic rs);
        stall = st; redirect_valid = rv; redirect_target = tg;
        call_valid = cv; ret_valid = rt; halt = hl; resume = rs;
    endtask

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [AW-1:0] ea, input logic ef,
                           input logic [1:0] es, input logic eo, input logic eu);
        chk({tag, ".address"}, address, ea);
        chk({tag, ".fetch_valid"}, AW'(fetch_valid), AW'(ef));
        chk({tag, ".state"}, AW'(state), AW'(es));
        chk({tag, ".ras_overflow"}, AW'(ras_overflow), AW'(eo));
        chk({tag, ".ras_underflow"}, AW'(ras_underflow), AW'(eu));
    endtask

    // Reference model: a return-address queue with front = most recent call.
    logic [AW-1:0] m_addr;
    logic          m_fv, m_ovf, m_unf;
    int            m_st;
    int            m_boot;
    logic [AW-1:0] m_ras[$];

    task automatic m_reset();
        m_addr = '0; m_fv = 1'b0; m_st = 0; m_ovf = 1'b0; m_unf = 1'b0;
        m_boot = 0; m_ras.delete();
    endtask

    task automatic m_step(input logic st, input logic rv, input logic [AW-1:0] tg,
                          input logic cv, input logic rt, input logic hl, input logic rs);
        m_fv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        if (m_st == 0) begin
            m_boot++;
            if (m_boot >= 2) begin
                m_st = 1; m_fv = 1'b1;
            end
        end else if (m_st == 1) begin
            if (hl) begin
                m_st = 2;
            end else if (rv) begin
                if (cv) begin
                    m_ras.push_front(m_addr + AW'(1));
                    if (m_ras.size() > 4) begin
                        void'(m_ras.pop_back());
                        m_ovf = 1'b1;
                    end
                end
                m_addr = tg; m_fv = 1'b1;
            end else if (rt) begin
                if (m_ras.size() == 0) begin
                    m_addr = m_addr + AW'(1); m_unf = 1'b1;
                end else begin
                    m_addr = m_ras.pop_front();
                end
                m_fv = 1'b1;
            end else if (!st) begin
                m_addr = m_addr + AW'(1); m_fv = 1'b1;
            end
        end else if (rs && !hl) begin
            m_st = 1; m_fv = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        logic [95:0] wide;
        logic [AW-1:0] tg;
        logic st, rv, cv, rt, hl, rs;

        // Boot and sequential stepping 0..9.
        vecs.push_back(mk(0,0,A(0),0,0,0,0, A(0),0,0,0,0));
        vecs.push_back(mk(0,0,A(0),0,0,0,0, A(0),1,1,0,0));
        for (int i = 1; i <= 9; i++) vecs.push_back(mk(0,0,A(0),0,0,0,0, A(i),1,1,0,0));
        // Stall at 5.
        vecs.push_back(mk(0,1,A(5),0,0,0,0, A(5),1,1,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,A(0),0,0,0,0, A(5),0,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,0,0,0, A(6),1,1,0,0));
        // Call from 3, return to 4, then empty RAS underflows.
        vecs.push_back(mk(0,1,A(3),0,0,0,0, A(3),1,1,0,0));
        vecs.push_back(mk(0,1,A('h40),1,0,0,0, A('h40),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,0,0,0, A('h41),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A(4),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A(5),1,1,0,1));
        // Five calls: fifth overflows, four LIFO returns, fifth return underflows.
        vecs.push_back(mk(0,1,A('h100),1,0,0,0, A('h100),1,1,0,0));
        vecs.push_back(mk(0,1,A('h200),1,0,0,0, A('h200),1,1,0,0));
        vecs.push_back(mk(0,1,A('h300),1,0,0,0, A('h300),1,1,0,0));
        vecs.push_back(mk(0,1,A('h400),1,0,0,0, A('h400),1,1,0,0));
        vecs.push_back(mk(0,1,A('h500),1,0,0,0, A('h500),1,1,1,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A('h401),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A('h301),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A('h201),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A('h101),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A('h102),1,1,0,1));
        // Halt at 7; controls ignored in HALT; halt+resume stays; resume restarts at 7.
        vecs.push_back(mk(0,1,A(7),0,0,0,0, A(7),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,0,1,0, A(7),0,2,0,0));
        vecs.push_back(mk(1,1,A('h99),1,1,0,0, A(7),0,2,0,0));
        vecs.push_back(mk(0,0,A(0),0,0,1,1, A(7),0,2,0,0));
        vecs.push_back(mk(0,0,A(0),0,0,0,1, A(7),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,0,0,0, A(8),1,1,0,0));
        // Wrap from all-ones.
        vecs.push_back(mk(0,1,ONES,0,0,0,0, ONES,1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,0,0,0, A(0),1,1,0,0));
        // Redirect beats stall; redirect beats return (no pop).
        vecs.push_back(mk(1,1,A('h10),0,0,0,0, A('h10),1,1,0,0));
        vecs.push_back(mk(0,1,A('h20),1,1,0,0, A('h20),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A('h11),1,1,0,0));
        vecs.push_back(mk(0,0,A(0),0,1,0,0, A('h12),1,1,0,1));

        drive(0, 0, '0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", '0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].rv, vecs[i].tg, vecs[i].cv, vecs[i].rt,
                  vecs[i].hl, vecs[i].rs);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_fv, vecs[i].e_st,
                    vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Mid-run reset with a pending return address on the stack.
        drive(0, 1, A('h20), 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("mid_call", A('h20), 1'b1, 2'd1, 1'b0, 1'b0);
        drive(0, 0, '0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk_all("mid_rst_async", '0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("mid_rst_held", '0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all("mid_boot0", '0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_all("mid_boot1", '0, 1'b1, 2'd1, 1'b0, 1'b0);
        drive(0, 0, '0, 0, 1, 0, 0);
        @(posedge clk); #1;
        chk_all("mid_ret_unf", A(1), 1'b1, 2'd1, 1'b0, 1'b1);

        // Random stimulus against the reference model.
        drive(0, 0, '0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                drive(0, 0, '0, 0, 0, 0, 0);
                reset = 1'b0;
                m_reset();
                #1;
                chk_all($sformatf("rnd_rst%0d", i), m_addr, m_fv, 2'(m_st), m_ovf, m_unf);
                @(negedge clk);
                reset = 1'b1;
            end
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 4) == 0);
            cv = ($urandom_range(0, 1) == 0);
            rt = ($urandom_range(0, 3) == 0);
            hl = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                tg = ONES - AW'($urandom_range(0, 2));
            end else begin
                wide = {$urandom, $urandom, $urandom};
                tg = wide[AW-1:0];
            end
            drive(st, rv, tg, cv, rt, hl, rs);
            m_step(st, rv, tg, cv, rt, hl, rs);
            @(posedge clk);
            #1;
            chk_all($sformatf("rnd%0d", i), m_addr, m_fv, 2'(m_st), m_ovf, m_unf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
